// File: rtl/conv33_pkg.sv
// Shared types and constants for the conv33 sequencer.
package conv33_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv33_state_t;

  localparam logic [3:0] CFG_W0    = 4'd0;
  localparam logic [3:0] CFG_W8    = 4'd8;
  localparam logic [3:0] CFG_BIAS  = 4'd9;
  localparam logic [3:0] CFG_SCALE = 4'd10;

  // Number of valid 3x3 windows in an h x w map (stride 1, no padding).
  function automatic int unsigned result_total(input int unsigned h, input int unsigned w);
    return (h - 2) * (w - 2);
  endfunction

endpackage

// File: rtl/conv33_line_buf.sv
// Two column-indexed line buffers; taps are read before the shift writes.
module conv33_line_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 28,
  parameter int COL_W      = $clog2(IMG_W)
) (
  input  logic                  clk,
  input  logic                  shift_en,
  input  logic [COL_W-1:0]      col,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] tap0,
  output logic [DATA_WIDTH-1:0] tap1
);

  logic [DATA_WIDTH-1:0] lb0 [IMG_W];
  logic [DATA_WIDTH-1:0] lb1 [IMG_W];

  assign tap0 = lb0[col];
  assign tap1 = lb1[col];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb1[col] <= lb0[col];
      lb0[col] <= din;
    end
  end

endmodule

// File: rtl/conv33_ctrl.sv
// Sequencer for one 3x3 conv pass: config regs, window build, result counting.
//   state | meaning
//   IDLE  | config writes accepted, waiting for start
//   RUN   | accepting pixels, building windows
//   DRAIN | input closed, waiting for the last calc results
//   DONE  | one-cycle done pulse
module conv33_ctrl
  import conv33_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BIAS_WIDTH = 32,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int CNT_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_addr,
  input  logic [BIAS_WIDTH-1:0]   cfg_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [DATA_WIDTH-1:0]   pix_data,
  output logic [9*DATA_WIDTH-1:0] win_data,
  output logic [9*DATA_WIDTH-1:0] weight_data,
  output logic [BIAS_WIDTH-1:0]   bias,
  output logic [BIAS_WIDTH-1:0]   scale,
  output logic                    conv33_en,
  input  logic                    calc_valid,
  output logic [CNT_W-1:0]        res_count,
  output logic                    busy,
  output logic                    done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [CNT_W-1:0] RES_TOTAL = CNT_W'(result_total(IMG_H, IMG_W));

  conv33_state_t         state;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  accept;
  logic [DATA_WIDTH-1:0] tap0;
  logic [DATA_WIDTH-1:0] tap1;

  assign accept = pix_valid && pix_ready;

  conv33_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .COL_W      (COL_W)
  ) u_line_buf (
    .clk      (clk),
    .shift_en (accept),
    .col      (col),
    .din      (pix_data),
    .tap0     (tap0),
    .tap1     (tap1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      conv33_en <= 1'b0;
      col       <= '0;
      row       <= '0;
      res_count <= '0;
    end else begin
      conv33_en <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            pix_ready <= 1'b1;
            busy      <= 1'b1;
            col       <= '0;
            row       <= '0;
            res_count <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            conv33_en <= (row >= ROW_W'(2)) && (col >= COL_W'(2));
            if (col == COL_W'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 1'b1;
              if (row == ROW_W'(IMG_H - 1)) begin
                state     <= ST_DRAIN;
                pix_ready <= 1'b0;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (res_count == RES_TOTAL) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      // Results only count while a pass is open; the counter sticks at max.
      if ((state == ST_RUN || state == ST_DRAIN) && calc_valid && (res_count != '1))
        res_count <= res_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight_data <= '0;
      bias        <= '0;
      scale       <= '0;
    end else if (state == ST_IDLE && cfg_we) begin
      for (int k = 0; k < 9; k++) begin
        if (cfg_addr == CFG_W0 + 4'(k))
          weight_data[k*DATA_WIDTH +: DATA_WIDTH] <= cfg_data[DATA_WIDTH-1:0];
      end
      if (cfg_addr == CFG_BIAS)
        bias <= cfg_data;
      if (cfg_addr == CFG_SCALE)
        scale <= cfg_data;
    end
  end

  // Window rows: 0 = two lines back (lb1), 1 = previous line (lb0), 2 = current pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_data <= '0;
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        win_data[(3*i)*DATA_WIDTH   +: DATA_WIDTH] <= win_data[(3*i+1)*DATA_WIDTH +: DATA_WIDTH];
        win_data[(3*i+1)*DATA_WIDTH +: DATA_WIDTH] <= win_data[(3*i+2)*DATA_WIDTH +: DATA_WIDTH];
      end
      win_data[2*DATA_WIDTH +: DATA_WIDTH] <= tap1;
      win_data[5*DATA_WIDTH +: DATA_WIDTH] <= tap0;
      win_data[8*DATA_WIDTH +: DATA_WIDTH] <= pix_data;
    end
  end

endmodule

// File: doc/conv33_ctrl.md
Name: conv33_ctrl

Overview:
Sequencer for one 3x3 conv pass through the conv33 calc datapath (stride 1, no padding) over an IMG_H x IMG_W single-channel feature map.
- Holds the kernel configuration: 9 weights, bias and scale.
- Accepts a raster-order pixel stream using valid/ready.
- Builds the 3x3 window with two line buffers and drives the calc's enable.
- Counts the calc's valid pulses and signals completion.

Parameters:
- DATA_WIDTH, 8: pixel/weight width.
- BIAS_WIDTH, 32: bias/scale width; also the cfg_data width.
- IMG_W, 28: input columns, 3..1023.
- IMG_H, 28: input rows, 3..1023.
- CNT_W, 20: width of the result counter; must hold (IMG_H-2)*(IMG_W-2).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  begin a pass; sampled only in IDLE
- cfg_we  in  1  config write strobe; accepted only in IDLE
- cfg_addr  in  4  0-8 weight_k, 9 bias, 10 scale, 11-15 ignored
- cfg_data  in  BIAS_WIDTH  config value; weights take bits [DATA_WIDTH-1:0]
- pix_valid  in  1  pixel offered
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_data  in  DATA_WIDTH  signed pixel
- win_data  out  9*DATA_WIDTH  window; slice (3*i+j) is data_i_j; row 0 is oldest, col 0 is leftmost
- weight_data  out  9*DATA_WIDTH  slice k is weight_k
- bias  out  BIAS_WIDTH  registered bias
- scale  out  BIAS_WIDTH  registered scale
- conv33_en  out  1  window valid this cycle; drives calc enable
- calc_valid  in  1  result-valid pulse from calc
- res_count  out  CNT_W  results received this pass
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of pass

Behaviour:
Interface:
- Reset rst, asynchronous, active-high; clock clk.

Reset values:
- State IDLE.
- All outputs 0: pix_ready, conv33_en, busy, done, res_count, win_data, weight_data, bias, scale.
- Internal col/row counters 0.
- Line-buffer contents are don't-care.

States:
- IDLE
  - cfg_we writes the addressed register on the next edge.
  - start moves to RUN; on entry, row, col and res_count clear to 0.
- RUN
  - pix_ready=1.
  - On each accept:
    - shift the window left;
    - the new right column is {lb1[col], lb0[col], pix_data} (top to bottom);
    - lb1[col]<=lb0[col]; lb0[col]<=pix_data;
    - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - conv33_en is registered: high on the cycle after an accept whose pre-increment row>=2 and col>=2; otherwise 0. win_data is updated on the same edge.
  - No accept means no conv33_en, and the window holds.
  - Accept of pixel (IMG_H-1, IMG_W-1) moves to DRAIN.
- DRAIN
  - pix_ready=0.
  - Exit to DONE once res_count == (IMG_H-2)*(IMG_W-2). This includes the case where the final calc_valid arrives in the same cycle as entry.
- DONE
  - done=1 for one cycle, then IDLE.

Counting and control rules:
- res_count increments on every calc_valid in RUN or DRAIN, saturating at its max. calc_valid is ignored in IDLE and DONE.
- The calc registers its result one cycle after conv33_en, so the last calc_valid arrives 2 cycles after the last accept.
- start, and cfg_we outside IDLE, are ignored with no side effects. Config is stable for the whole pass.
- Reset mid-pass: immediate return to IDLE, config cleared to 0, no done pulse.
- Arithmetic: counters are unsigned. Data fields are passed through unchanged, signedness preserved.

Decomposition:
- Package conv33_pkg:
  - state encoding (IDLE, RUN, DRAIN, DONE);
  - cfg address constants (CFG_W0=0 .. CFG_W8=8, CFG_BIAS=9, CFG_SCALE=10);
  - localparam function for the result total.
- Sub-module conv33_line_buf:
  - two IMG_W-deep DATA_WIDTH registers/RAM;
  - column-indexed read-before-write on shift enable;
  - outputs the two column taps.
- FSM, counters, window registers and config registers stay in conv33_ctrl.

Test Plan:
- Config: in IDLE write addr k with value k+1 (k=0..8), bias=100, scale=0x10000 -> weight_data slices 1..9, bias=100, scale=65536. A cfg write with addr 12 changes nothing.
- 4x4 image (IMG_W=IMG_H=4), pixels 0..15 with continuous valid, calc model echoes conv33_en delayed 1 cycle:
  - first conv33_en on the cycle after the pixel-10 accept, with win_data = {0,1,2,4,5,6,8,9,10};
  - exactly 4 en pulses, windows centred at 5, 6, 9, 10;
  - res_count=4, then one done pulse, busy falls with it.
- Backpressure: same image with pix_valid toggling every other cycle -> same 4 windows in order; no conv33_en in any cycle not preceded by an accept.
- Ignored controls: start and cfg_we pulsed mid-RUN -> no restart, weights unchanged, pass completes normally.
- Reset after pixel 7: pix_ready=0, busy=0, weights 0, no done. A fresh start then completes a full pass correctly.
- Calc valid lagging 3 extra cycles -> FSM stays in DRAIN until res_count=4, then done.
